sha_job_scheduler: RTL and testbench

- Sequences a pool of NUM_CORES parallel SHA-256 nonce cores for one bitcoin-hash job.
- Hands out nonces 0..NUM_NONCES-1 to idle cores and collects each core's 32-bit hash word.
- Arbitrates the single shared memory write port round-robin, storing each result at output_addr + nonce.
- Sits between the top-level start/done interface and the core array; cores do their own message reads from message_addr.

---
 rtl/sha_job_scheduler.sv | 174 +++++++++++++++++
 tb/tb_sha_job_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_job_scheduler.sv
// sha_job_scheduler: hands nonces 0..NUM_NONCES-1 to a pool of SHA-256 cores
// and writes each returned hash word to output_addr + nonce through one shared
// memory write port, arbitrated round-robin.
// Optional build macro SCHED_PERF_EN adds perf_cycles / perf_stall counters.
module sha_job_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int NUM_NONCES = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [15:0]              message_addr,
  input  logic [15:0]              output_addr,
  output logic                     done,
  output logic                     mem_clk,
  output logic                     mem_we,
  output logic [15:0]              mem_addr,
  output logic [31:0]              mem_write_data,
  output logic [15:0]              core_msg_addr,
  output logic [NUM_CORES-1:0]     core_start,
  output logic [31:0]              core_nonce,
  input  logic [NUM_CORES-1:0]     core_result_valid,
  input  logic [32*NUM_CORES-1:0]  core_result,
  output logic [NUM_CORES-1:0]     core_result_ack
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]              perf_cycles,
  output logic [31:0]              perf_stall
`endif
);

  localparam int unsigned NC = NUM_CORES;
  localparam int unsigned IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [16:0] NN = 17'(NUM_NONCES);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  typedef enum logic {FREE, BUSY} core_state_t;

  state_t        state;
  core_state_t   core_st      [NUM_CORES];
  logic [31:0]   core_nonce_q [NUM_CORES];
  logic [31:0]   res_word     [NUM_CORES];
  logic [15:0]   out_base;
  logic [16:0]   next_nonce;
  logic [16:0]   written;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] disp_idx;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand_idx;
  logic          disp_hit;
  logic          win_hit;
  logic          any_free;
  logic          in_run;
  logic          more_nonces;

  assign mem_clk     = clk;
  assign done        = (state == FIN);
  assign in_run      = (state == RUN);
  assign more_nonces = (next_nonce < NN);

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign res_word[g] = core_result[32*g +: 32];
  end

  // Dispatch: start the lowest-index FREE core with the next nonce
  always_comb begin
    disp_hit   = 1'b0;
    disp_idx   = '0;
    any_free   = 1'b0;
    core_start = '0;
    core_nonce = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      if (core_st[i] == FREE) begin
        if (!any_free) disp_idx = IW'(i);
        any_free = 1'b1;
      end
    end
    if (in_run && more_nonces && any_free) begin
      disp_hit             = 1'b1;
      core_start[disp_idx] = 1'b1;
      core_nonce           = {15'b0, next_nonce};
    end
  end

  // Round-robin pick among BUSY cores holding a result, starting after rr_ptr
  always_comb begin
    win_hit  = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
    if (in_run) begin
      for (int unsigned off = 1; off <= NC; off++) begin
        cand_idx = IW'((32'(rr_ptr) + off) % NC);
        if (!win_hit && core_st[cand_idx] == BUSY && core_result_valid[cand_idx]) begin
          win_hit = 1'b1;
          win_idx = cand_idx;
        end
      end
    end
  end

  // Write port and acknowledge for the arbitration winner, zero otherwise
  always_comb begin
    mem_we          = win_hit;
    mem_addr        = '0;
    mem_write_data  = '0;
    core_result_ack = '0;
    if (win_hit) begin
      mem_addr                 = out_base + core_nonce_q[win_idx][15:0];
      mem_write_data           = res_word[win_idx];
      core_result_ack[win_idx] = 1'b1;
    end
  end

  // Job FSM plus per-core FREE/BUSY tracking and nonce/write counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      out_base      <= '0;
      core_msg_addr <= '0;
      next_nonce    <= '0;
      written       <= '0;
      rr_ptr        <= IW'(NC - 1);
      for (int unsigned i = 0; i < NC; i++) begin
        core_st[i]      <= FREE;
        core_nonce_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            core_msg_addr <= message_addr;
            out_base      <= output_addr;
            next_nonce    <= '0;
            written       <= '0;
            state         <= RUN;
          end
        end
        RUN: begin
          // A dispatch targets a FREE core and a write a BUSY one, so both
          // updates can land on the same edge without colliding.
          if (disp_hit) begin
            core_st[disp_idx]      <= BUSY;
            core_nonce_q[disp_idx] <= core_nonce;
            next_nonce             <= next_nonce + 17'd1;
          end
          if (win_hit) begin
            core_st[win_idx] <= FREE;
            rr_ptr           <= win_idx;
            written          <= written + 17'd1;
          end
          if (written + 17'(win_hit) == NN) state <= FIN;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_PERF_EN
  // Saturating RUN-cycle and dispatch-stall counters, cleared on job start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state == IDLE && start) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (in_run) begin
      if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (more_nonces && !any_free && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha_job_scheduler.sv
// Testbench for sha_job_scheduler: randomized core latencies, spurious valids
// and stray start pulses, checked cycle by cycle against a behavioural model.
module tb_sha_job_scheduler;

  localparam int NC = 4;
  localparam int NN = 16;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [15:0]        message_addr = '0;
  logic [15:0]        output_addr = '0;
  logic               done;
  logic               mem_clk;
  logic               mem_we;
  logic [15:0]        mem_addr;
  logic [31:0]        mem_write_data;
  logic [15:0]        core_msg_addr;
  logic [NC-1:0]      core_start;
  logic [31:0]        core_nonce;
  logic [NC-1:0]      core_result_valid = '0;
  logic [32*NC-1:0]   core_result = '0;
  logic [NC-1:0]      core_result_ack;

  int errors = 0;
  int checks = 0;

  // reference model of the scheduler
  int          m_phase;   // 0 idle, 1 running, 2 finishing
  int          m_next;
  int          m_written;
  int          m_ptr;
  bit          m_busy  [NC];
  logic [31:0] m_nonce [NC];
  logic [15:0] m_base;
  logic [15:0] m_msg;

  // behavioural cores
  int          cdly   [NC];
  bit          cready [NC];
  bit          cval   [NC];
  logic [31:0] cdat   [NC];

  bit sync_mode, spur_mode, rand_start, start_req;
  int lat_fix;
  int n_writes, done_cnt;
  int obs_start [NN];

  always #5 clk = ~clk;

  sha_job_scheduler #(.NUM_CORES(NC), .NUM_NONCES(NN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .message_addr(message_addr), .output_addr(output_addr),
    .done(done), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .core_msg_addr(core_msg_addr),
    .core_start(core_start), .core_nonce(core_nonce),
    .core_result_valid(core_result_valid), .core_result(core_result),
    .core_result_ack(core_result_ack)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_next = 0; m_written = 0; m_ptr = NC - 1;
    m_base = '0; m_msg = '0;
    for (int i = 0; i < NC; i++) begin
      m_busy[i] = 1'b0;
      m_nonce[i] = '0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_we"}, 32'(mem_we), 0);
    check({tag, "_addr"}, 32'(mem_addr), 0);
    check({tag, "_wdata"}, mem_write_data, 0);
    check({tag, "_msg"}, 32'(core_msg_addr), 0);
    check({tag, "_cstart"}, 32'(core_start), 0);
    check({tag, "_cnonce"}, core_nonce, 0);
    check({tag, "_ack"}, 32'(core_result_ack), 0);
  endtask

  // One clock: drive inputs after the edge, check mid-cycle, advance the model
  task automatic cycle();
    logic [NC-1:0] e_start, e_ack;
    logic [31:0]   e_nonce, e_data;
    logic [15:0]   e_addr;
    logic          e_we;
    bit            all_ready;
    int            d, w, c;

    @(posedge clk); #1;
    for (int i = 0; i < NC; i++) begin
      if (cdly[i] > 0) begin
        cdly[i]--;
        if (cdly[i] == 0) begin
          cready[i] = 1'b1;
          cdly[i] = -1;
        end
      end
    end
    all_ready = 1'b1;
    for (int i = 0; i < NC; i++) if (!cready[i]) all_ready = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (cready[i] && (!sync_mode || all_ready)) begin
        cval[i] = 1'b1;
        cready[i] = 1'b0;
      end
      core_result_valid[i] = cval[i] | (spur_mode && !m_busy[i] && $urandom_range(0, 2) == 0);
      core_result[32*i +: 32] = cval[i] ? cdat[i] : $urandom;
    end
    start = start_req | (rand_start && m_phase != 0 && $urandom_range(0, 5) == 0);
    if (!start_req && rand_start) output_addr = 16'($urandom);
    start_req = 1'b0;

    @(negedge clk);
    e_start = '0; e_nonce = '0; d = -1;
    if (m_phase == 1 && m_next < NN) begin
      for (int i = 0; i < NC; i++) if (d < 0 && !m_busy[i]) d = i;
      if (d >= 0) begin
        e_start[d] = 1'b1;
        e_nonce = 32'(m_next);
      end
    end
    w = -1;
    if (m_phase == 1) begin
      for (int k = 1; k <= NC; k++) begin
        c = (m_ptr + k) % NC;
        if (w < 0 && m_busy[c] && core_result_valid[c]) w = c;
      end
    end
    e_we = (w >= 0); e_addr = '0; e_data = '0; e_ack = '0;
    if (w >= 0) begin
      e_addr = m_base + m_nonce[w][15:0];
      e_data = m_nonce[w] ^ 32'hA5A5A5A5;
      e_ack[w] = 1'b1;
    end
    check("mem_clk", 32'(mem_clk), 32'(clk));
    check("done", 32'(done), 32'(m_phase == 2));
    check("core_start", 32'(core_start), 32'(e_start));
    check("core_nonce", core_nonce, e_nonce);
    check("core_msg_addr", 32'(core_msg_addr), 32'(m_msg));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    check("mem_write_data", mem_write_data, e_data);
    check("core_result_ack", 32'(core_result_ack), 32'(e_ack));

    // observations for end-of-job accounting and the behavioural cores
    if (mem_we) n_writes++;
    if (done) done_cnt++;
    for (int i = 0; i < NC; i++) begin
      if (core_result_ack[i]) cval[i] = 1'b0;
      if (core_start[i]) begin
        if (core_nonce < NN) obs_start[core_nonce]++;
        cval[i] = 1'b0;
        cready[i] = 1'b0;
        cdat[i] = core_nonce ^ 32'hA5A5A5A5;
        cdly[i] = (lat_fix > 0) ? lat_fix : $urandom_range(1, 8);
      end
    end

    case (m_phase)
      0: if (start) begin
        m_phase = 1; m_base = output_addr; m_msg = message_addr;
        m_next = 0; m_written = 0;
      end
      1: begin
        if (d >= 0) begin
          m_busy[d] = 1'b1;
          m_nonce[d] = 32'(m_next);
          m_next++;
        end
        if (w >= 0) begin
          m_busy[w] = 1'b0;
          m_ptr = w;
          m_written++;
        end
        if (m_written == NN) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic run_job(input logic [15:0] base, input bit sync, input bit spur,
                         input bit rstart, input int lat, input int stop_after);
    sync_mode = sync; spur_mode = spur; rand_start = rstart; lat_fix = lat;
    output_addr = base;
    message_addr = 16'($urandom);
    n_writes = 0; done_cnt = 0;
    for (int n = 0; n < NN; n++) obs_start[n] = 0;
    start_req = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      cycle();
      if (stop_after > 0 && n_writes >= stop_after) break;
      if (done_cnt > 0 && m_phase == 0) break;
    end
    if (stop_after == 0) begin
      check("job_done_pulses", 32'(done_cnt), 1);
      check("job_writes", 32'(n_writes), NN);
      for (int n = 0; n < NN; n++) check("nonce_started_once", 32'(obs_start[n]), 1);
    end else begin
      check("partial_writes", 32'(n_writes), 32'(stop_after));
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NC; i++) begin
      cdly[i] = -1; cready[i] = 1'b0; cval[i] = 1'b0; cdat[i] = '0;
    end
    sync_mode = 0; spur_mode = 0; rand_start = 0; start_req = 0; lat_fix = 4;

    #12;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) cycle();

    // fixed four-cycle cores, consecutive start ordering
    run_job(16'h0100, 1'b0, 1'b0, 1'b0, 4, 0);
    // simultaneous results to exercise round-robin order
    run_job(16'h2000, 1'b1, 1'b0, 1'b0, 0, 0);
    // address wrap with spurious valids and stray start pulses
    run_job(16'hFFFE, 1'b0, 1'b1, 1'b1, 0, 0);
    rand_start = 1'b0;
    repeat (6) cycle();

    // abort a job after five writes
    run_job(16'h0400, 1'b0, 1'b1, 1'b0, 0, 5);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) cycle();
    run_job(16'h0300, 1'b0, 1'b1, 1'b0, 0, 0);
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
